ccc_apb_cfg_master: RTL
=======================

# ccc_apb_cfg_master

APB initiator that drives the dynamic-reconfiguration port of the fabric CCC. The CCC side is the APB responder: 6-bit address, 8-bit data, no PREADY. This block accepts single-register read and write requests from fabric control logic and runs fixed two-phase APB transfers. After a write it can optionally pulse the PLL asynchronous reset and wait, with a timeout, for the CCC LOCK output to return. It sits between the system controller and the CCC instance, in the CCC's APB clock domain.

## Interface
- LOCK_TIMEOUT, 4096: maximum number of PCLK cycles to wait for LOCK after a relock pulse; must be ≥ 2.
- ARST_CYCLES, 16: width of the PLL_ARST_N low pulse, in PCLK cycles; must be ≥ 1.

- PCLK  in  1  APB and control clock.
- PRESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block is idle and can accept a request.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  6  CCC register address.
- REQ_WDATA  in  8  write data.
- REQ_RELOCK  in  1  after a write, pulse PLL reset and wait for LOCK; ignored on reads.
- RSP_VALID  out  1  one-cycle response strobe; no backpressure.
- RSP_RDATA  out  8  read data, or readback data (see Configuration).
- RSP_ERR  out  1  LOCK timeout; qualified by RSP_VALID.
- RSP_MISMATCH  out  1  readback differs from written data; qualified by RSP_VALID.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PLL_ARST_N  out  1  CCC PLL reset, active-low.
- LOCK  in  1  CCC lock output; asynchronous to PCLK.
- LOCKED  out  1  LOCK after two-flop synchronisation.

## Operation
- States: IDLE, SETUP, ACCESS, RB_SETUP, RB_ACCESS, ARST, WAIT_LOCK, RESP.
- IDLE: REQ_READY=1. A request is accepted when REQ_VALID and REQ_READY are both 1. On acceptance, REQ_ADDR, REQ_WDATA, REQ_WRITE and REQ_RELOCK are captured and the FSM moves to SETUP.
- SETUP: PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA hold the captured values. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PRDATA is sampled on the closing edge when the transfer is a read. Next state:
  - read → RESP;
  - write, readback compiled in → RB_SETUP;
  - write with relock → ARST;
  - otherwise → RESP.
- RB_SETUP → RB_ACCESS: same as SETUP/ACCESS with PWRITE=0. PRDATA is captured, and mismatch = (PRDATA != captured wdata). Next state is ARST if relock, else RESP.
- ARST: PLL_ARST_N=0 for exactly ARST_CYCLES cycles, then WAIT_LOCK. The cycle counter is cleared on entry.
- WAIT_LOCK: the counter increments every cycle.
  - LOCKED=1 → RESP with ERR=0.
  - Counter reaches LOCK_TIMEOUT−1 with LOCKED=0 → RESP with ERR=1.
  - If both occur in the same cycle, LOCK wins (ERR=0).
- RESP: RSP_VALID=1 for one cycle, with RSP_RDATA, RSP_ERR and RSP_MISMATCH valid. Next state is IDLE.
- Outside SETUP, ACCESS, RB_SETUP and RB_ACCESS: PSEL=0, PENABLE=0. PADDR and PWDATA hold their last values.
- Counter width is $clog2(max(LOCK_TIMEOUT, ARST_CYCLES)) + 1; the counter never wraps.
- Reset, asynchronous and valid in any state: FSM → IDLE; any in-flight transfer is dropped with no response; PLL_ARST_N releases to 1 immediately.

## Timing
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RSP_MISMATCH=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PLL_ARST_N=1, LOCKED=0, synchroniser flops=0.
- REQ_READY rises in the first PCLK cycle after PRESET_N deasserts. It is 0 from the acceptance cycle until the cycle after RESP.
- All outputs are registered.
- Latencies, with acceptance on edge N:
  - SETUP is visible in cycle N+1 and ACCESS in N+2.
  - Plain read or write: RSP_VALID in N+3.
  - Write with readback: RSP_VALID in N+5.
  - Relock: PLL_ARST_N low for ARST_CYCLES cycles. RSP_VALID follows 1 cycle after the synchronised LOCK is seen, or after the timeout.
- LOCK-to-LOCKED latency is 2 cycles.
- Back-to-back requests: at most one request per 4 cycles (response cycle plus the return to IDLE).

## Configuration
- CCC_CFG_READBACK_EN defined:
  - every write is followed by an APB read of the same address;
  - RSP_RDATA carries the readback value;
  - RSP_MISMATCH reports whether it differs from the written data.
- Undefined:
  - RB states are not generated;
  - writes return RSP_RDATA=0 and RSP_MISMATCH=0;
  - reads are unaffected.

## Test plan
- Reset, then read addr 0x05 with PRDATA=0xA7 → PSEL/PENABLE sequence in cycles N+1/N+2; RSP_VALID in N+3 with RSP_RDATA=0xA7, RSP_ERR=0.
- Write addr 0x12, data 0x3C, no relock, macro off → PWRITE=1, PWDATA=0x3C; RSP_VALID in N+3, RSP_RDATA=0.
- Macro on: write 0x3C while the responder returns 0x3D → readback transfer follows; RSP_VALID in N+5 with RSP_RDATA=0x3D, RSP_MISMATCH=1.
- Write with relock, ARST_CYCLES=16, LOCK rising 100 cycles after PLL_ARST_N returns to 1 → PLL_ARST_N low for exactly 16 cycles; RSP_ERR=0; LOCKED=1.
- Write with relock, LOCK held 0, LOCK_TIMEOUT=64 → RSP_VALID after 64 WAIT_LOCK cycles with RSP_ERR=1; REQ_READY returns to 1.
- Assert PRESET_N during ARST → PLL_ARST_N=1 and PSEL=0 immediately, no RSP_VALID; after release a new read completes normally.

Source files
------------

// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master: APB initiator for the CCC reconfiguration port with optional PLL relock.
// Define CCC_CFG_READBACK_EN to follow every write with a readback and mismatch check.
module ccc_apb_cfg_master #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int ARST_CYCLES  = 16
) (
    input  logic       PCLK,
    input  logic       PRESET_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WRITE,
    input  logic [5:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    input  logic       REQ_RELOCK,
    output logic       RSP_VALID,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_ERR,
    output logic       RSP_MISMATCH,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [5:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    output logic       PLL_ARST_N,
    input  logic       LOCK,
    output logic       LOCKED
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > ARST_CYCLES) ? LOCK_TIMEOUT : ARST_CYCLES;
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ARST_LAST = CW'(ARST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, RB_SETUP, RB_ACCESS, ARST, WAIT_LOCK, RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          write_q, relock_q;
    logic [7:0]    rdata_q;
    logic          err_q, mis_q;
    logic [5:0]    paddr_q;
    logic [7:0]    pwdata_q;
    logic          sel_q, en_q, pwrite_q, arst_n_q, ready_q, rsp_valid_q;
    logic          sel_d, en_d, pwrite_d, arst_n_d, ready_d, rsp_valid_d;
    logic          accept;

    assign accept = (state_q == IDLE) && REQ_VALID && ready_q;

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = SETUP;
            SETUP:     state_d = ACCESS;
`ifdef CCC_CFG_READBACK_EN
            ACCESS:    state_d = write_q ? RB_SETUP : RESP;
            RB_SETUP:  state_d = RB_ACCESS;
            RB_ACCESS: state_d = relock_q ? ARST : RESP;
`else
            ACCESS:    state_d = relock_q ? ARST : RESP;
`endif
            ARST:      if (cnt_q == ARST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: if (sync_q[1] || cnt_q == TO_LAST) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change so ARST and WAIT_LOCK each count from zero.
    assign cnt_d = ((state_q == ARST || state_q == WAIT_LOCK) && state_d == state_q) ? cnt_q + CW'(1) : '0;

    always_comb begin
        sel_d       = state_d inside {SETUP, ACCESS, RB_SETUP, RB_ACCESS};
        en_d        = state_d inside {ACCESS, RB_ACCESS};
        pwrite_d    = accept ? REQ_WRITE : (state_d inside {RB_SETUP, RB_ACCESS}) ? 1'b0 : pwrite_q;
        arst_n_d    = state_d != ARST;
        ready_d     = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            pwrite_q    <= 1'b0;
            arst_n_q    <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            en_q        <= en_d;
            pwrite_q    <= pwrite_d;
            arst_n_q    <= arst_n_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            write_q  <= 1'b0;
            relock_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= REQ_ADDR;
                pwdata_q <= REQ_WDATA;
                write_q  <= REQ_WRITE;
                relock_q <= REQ_WRITE && REQ_RELOCK;
                rdata_q  <= '0;
                err_q    <= 1'b0;
                mis_q    <= 1'b0;
            end
            if (state_q == ACCESS && !write_q) rdata_q <= PRDATA;
`ifdef CCC_CFG_READBACK_EN
            if (state_q == RB_ACCESS) begin
                rdata_q <= PRDATA;
                mis_q   <= PRDATA != pwdata_q;
            end
`endif
            if (state_q == WAIT_LOCK && state_d == RESP) err_q <= !sync_q[1];
        end
    end

    // LOCK comes from the PLL and is asynchronous to PCLK.
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) sync_q <= '0;
        else           sync_q <= {sync_q[0], LOCK};
    end

    assign REQ_READY    = ready_q;
    assign RSP_VALID    = rsp_valid_q;
    assign RSP_RDATA    = rdata_q;
    assign RSP_ERR      = err_q;
    assign RSP_MISMATCH = mis_q;
    assign PSEL         = sel_q;
    assign PENABLE      = en_q;
    assign PWRITE       = pwrite_q;
    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign PLL_ARST_N   = arst_n_q;
    assign LOCKED       = sync_q[1];
endmodule
